// File: rtl/uart_alu_sequencer.sv
// Frame sequencer: collects A, B, opcode bytes from the UART, runs the ALU, then hands the result to the TX side. Optional SEQ_OPCODE_CHECK_EN adds o_op_err.
// Latency: opcode byte at cycle N gives o_tx_data and the o_tx_signal pulse at N+2; the next frame is accepted the cycle after i_tx_done.
// Backpressure: none; bytes arriving outside GET_A/GET_B/GET_OP are dropped, and stalled frames are abandoned after TIMEOUT_CYCLES.
module uart_alu_sequencer #(
    parameter int DATA_WIDTH     = 8,
    parameter int SIZEOP         = 6,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_WIDTH      = 20
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_rx_done,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_tx_done,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    output logic [DATA_WIDTH-1:0] o_alu_a,
    output logic [DATA_WIDTH-1:0] o_alu_b,
    output logic [SIZEOP-1:0]     o_alu_op,
    output logic                  o_tx_signal,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_busy,
    output logic                  o_timeout
`ifdef SEQ_OPCODE_CHECK_EN
    ,
    output logic                  o_op_err
`endif
);

    typedef enum logic [2:0] {
        GET_A   = 3'd0,
        GET_B   = 3'd1,
        GET_OP  = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, tx_data_q, tx_data_d;
    logic [SIZEOP-1:0]     op_q, op_d;
    logic                  tx_sig_q, tx_sig_d;
    logic                  timeout_q, timeout_d;
    logic                  expired;
    logic                  op_ok;
    logic                  err_q, err_d;

    assign expired = (cnt_q == CNT_LAST);

`ifdef SEQ_OPCODE_CHECK_EN
    assign op_ok = op_q inside {SIZEOP'(32'h20), SIZEOP'(32'h22), SIZEOP'(32'h24),
                                SIZEOP'(32'h25), SIZEOP'(32'h26), SIZEOP'(32'h27),
                                SIZEOP'(32'h03), SIZEOP'(32'h02)};
`else
    assign op_ok = 1'b1;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= GET_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            GET_A:   if (i_rx_done) state_d = GET_B;
            GET_B:   if (i_rx_done) state_d = GET_OP;
                     else if (expired) state_d = GET_A;
            GET_OP:  if (i_rx_done) state_d = EXEC;
                     else if (expired) state_d = GET_A;
            EXEC:    state_d = SEND;
            SEND:    state_d = WAIT_TX;
            WAIT_TX: if (i_tx_done) state_d = GET_A;
            default: state_d = GET_A;
        endcase
    end

    // A received byte always beats timeout expiry in the same cycle.
    always_comb begin
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        tx_data_d = tx_data_q;
        tx_sig_d  = 1'b0;
        timeout_d = 1'b0;
        err_d     = err_q;
        case (state_q)
            GET_A: begin
                if (i_rx_done) begin
                    a_d   = i_rx_data;
                    cnt_d = '0;
                end
            end
            GET_B: begin
                if (i_rx_done) begin
                    b_d   = i_rx_data;
                    cnt_d = '0;
                end else if (expired) begin
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            GET_OP: begin
                if (i_rx_done) begin
                    op_d = i_rx_data[SIZEOP-1:0];
                end else if (expired) begin
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            EXEC: begin
                tx_data_d = op_ok ? i_alu_result : DATA_WIDTH'(8'hEE);
                err_d     = ~op_ok;
                tx_sig_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            tx_data_q <= '0;
            tx_sig_q  <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            tx_data_q <= tx_data_d;
            tx_sig_q  <= tx_sig_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
        end
    end

    assign o_alu_a     = a_q;
    assign o_alu_b     = b_q;
    assign o_alu_op    = op_q;
    assign o_tx_data   = tx_data_q;
    assign o_tx_signal = tx_sig_q;
    assign o_timeout   = timeout_q;
    assign o_busy      = (state_q != GET_A);
`ifdef SEQ_OPCODE_CHECK_EN
    assign o_op_err    = err_q;
`endif

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Bench for uart_alu_sequencer: directed frames, then random byte/tx_done/reset traffic against a frame-level model.
module tb_uart_alu_sequencer;

    localparam int T = 16;

    logic       i_clock = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_rx_done = 1'b0;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_tx_done = 1'b0;
    logic [7:0] i_alu_result;
    logic [7:0] o_alu_a, o_alu_b, o_tx_data;
    logic [5:0] o_alu_op;
    logic       o_tx_signal, o_busy, o_timeout;
`ifdef SEQ_OPCODE_CHECK_EN
    logic       o_op_err;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 i_clock = ~i_clock;

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        logic signed [7:0] sa;
        sa = a;
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h03:   return sa >>> b[2:0];
            6'h02:   return a >> b[2:0];
            default: return 8'h5A;
        endcase
    endfunction

    function automatic bit op_valid(input logic [5:0] op);
        return op inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
    endfunction

    assign i_alu_result = alu_f(o_alu_a, o_alu_b, o_alu_op);

    uart_alu_sequencer #(
        .DATA_WIDTH     (8),
        .SIZEOP         (6),
        .TIMEOUT_CYCLES (T),
        .CNT_WIDTH      (20)
    ) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_rx_done    (i_rx_done),
        .i_rx_data    (i_rx_data),
        .i_tx_done    (i_tx_done),
        .i_alu_result (i_alu_result),
        .o_alu_a      (o_alu_a),
        .o_alu_b      (o_alu_b),
        .o_alu_op     (o_alu_op),
        .o_tx_signal  (o_tx_signal),
        .o_tx_data    (o_tx_data),
        .o_busy       (o_busy),
        .o_timeout    (o_timeout)
`ifdef SEQ_OPCODE_CHECK_EN
        ,
        .o_op_err     (o_op_err)
`endif
    );

    // Frame-level model: bytes collected so far, cycles since the opcode, idle gap length.
    logic [7:0] m_a, m_b, m_txd;
    logic [5:0] m_op;
    bit         m_tsig, m_to, m_err;
    int         m_got, m_post, m_idle;

    task automatic model_step(input bit rx, input logic [7:0] d, input bit txd, input bit rst);
        m_tsig = 0;
        m_to   = 0;
        if (rst) begin
            m_a = 0; m_b = 0; m_op = 0; m_txd = 0; m_err = 0;
            m_got = 0; m_post = 0; m_idle = 0;
        end else if (m_got < 3) begin
            if (rx) begin
                if (m_got == 0) m_a = d;
                else if (m_got == 1) m_b = d;
                else m_op = d[5:0];
                m_got++;
                m_idle = 0;
                if (m_got == 3) m_post = 1;
            end else if (m_got > 0) begin
                if (m_idle == T - 1) begin
                    m_got = 0; m_idle = 0; m_to = 1;
                end else begin
                    m_idle++;
                end
            end
        end else if (m_post == 1) begin
`ifdef SEQ_OPCODE_CHECK_EN
            m_err = !op_valid(m_op);
            m_txd = m_err ? 8'hEE : alu_f(m_a, m_b, m_op);
`else
            m_txd = alu_f(m_a, m_b, m_op);
`endif
            m_tsig = 1;
            m_post = 2;
        end else if (m_post == 2) begin
            m_post = 3;
        end else if (txd) begin
            m_got = 0; m_post = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic cmp_all();
        chk("alu_a", 32'(o_alu_a), 32'(m_a));
        chk("alu_b", 32'(o_alu_b), 32'(m_b));
        chk("alu_op", 32'(o_alu_op), 32'(m_op));
        chk("tx_data", 32'(o_tx_data), 32'(m_txd));
        chk("tx_signal", 32'(o_tx_signal), 32'(m_tsig));
        chk("timeout", 32'(o_timeout), 32'(m_to));
        chk("busy", 32'(o_busy), 32'(m_got != 0));
`ifdef SEQ_OPCODE_CHECK_EN
        chk("op_err", 32'(o_op_err), 32'(m_err));
`endif
    endtask

    task automatic cyc(input bit rx, input logic [7:0] d, input bit txd, input bit rst);
        i_rx_done = rx;
        i_rx_data = d;
        i_tx_done = txd;
        i_reset   = rst;
        model_step(rx, d, txd, rst);
        @(posedge i_clock);
        #1;
        cmp_all();
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        cyc(1, a, 0, 0);
        cyc(1, b, 0, 0);
        cyc(1, op, 0, 0);
    endtask

    logic [7:0] ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

    initial begin
        #1;
        cyc(0, 8'h00, 0, 1);
        cyc(0, 8'h00, 0, 1);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_txdata", 32'(o_tx_data), 32'd0);

        frame(8'h05, 8'h03, 8'h20);
        chk("ops_a", 32'(o_alu_a), 32'h05);
        chk("ops_op", 32'(o_alu_op), 32'h20);
        cyc(0, 8'h00, 0, 0);
        chk("add_res", 32'(o_tx_data), 32'h08);
        chk("add_pulse", 32'(o_tx_signal), 32'd1);
        cyc(0, 8'h00, 0, 0);
        chk("pulse_end", 32'(o_tx_signal), 32'd0);
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 1, 0);
        chk("idle_busy", 32'(o_busy), 32'd0);

        frame(8'h10, 8'h01, 8'hE2);
        chk("op_mask", 32'(o_alu_op), 32'h22);
        cyc(0, 8'h00, 0, 0);
        chk("sub_res", 32'(o_tx_data), 32'h0F);
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 1, 0);

        cyc(1, 8'h07, 0, 0);
        for (int i = 0; i < T; i++) cyc(0, 8'h00, 0, 0);
        chk("to_pulse", 32'(o_timeout), 32'd1);
        chk("to_idle", 32'(o_busy), 32'd0);
        frame(8'h01, 8'h02, 8'h20);
        cyc(0, 8'h00, 0, 0);
        chk("after_to", 32'(o_tx_data), 32'h03);
        cyc(0, 8'h00, 0, 0);

        cyc(1, 8'h55, 0, 0);
        chk("drop_wait", 32'(o_alu_a), 32'h01);
        cyc(0, 8'h00, 1, 0);
        frame(8'h0C, 8'h0A, 8'h24);
        cyc(0, 8'h00, 0, 0);
        chk("and_res", 32'(o_tx_data), 32'h08);
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 1, 0);

        cyc(1, 8'hAA, 0, 0);
        cyc(1, 8'hBB, 0, 0);
        cyc(0, 8'h00, 0, 1);
        chk("midrst_a", 32'(o_alu_a), 32'd0);
        chk("midrst_sig", 32'(o_tx_signal), 32'd0);
        frame(8'h0F, 8'hF0, 8'h25);
        cyc(0, 8'h00, 0, 0);
        chk("or_res", 32'(o_tx_data), 32'hFF);
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 1, 0);

`ifdef SEQ_OPCODE_CHECK_EN
        frame(8'h01, 8'h02, 8'h3F);
        cyc(0, 8'h00, 0, 0);
        chk("bad_op_res", 32'(o_tx_data), 32'hEE);
        chk("bad_op_err", 32'(o_op_err), 32'd1);
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 1, 0);
        frame(8'h06, 8'h03, 8'h24);
        cyc(0, 8'h00, 0, 0);
        chk("good_op_err", 32'(o_op_err), 32'd0);
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 1, 0);
`endif

        for (int n = 0; n < 4000; n++) begin
            bit         rx, txd, rst;
            logic [7:0] d;
            rx  = ($urandom_range(0, 2) == 0);
            txd = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 299) == 0);
            d   = 8'($urandom);
            if (m_got == 2 && $urandom_range(0, 3) != 0) d = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 99) < 2) begin
                for (int k = 0; k < T + 2; k++) cyc(0, 8'h00, 0, 0);
            end
            cyc(rx, d, txd, rst);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_alu_sequencer.md
Name: uart_alu_sequencer

Overview:
- Frame controller between the UART receiver/transmitter and the combinational ALU.
- Collects three received bytes in order (operand A, operand B, opcode) and drives them to the ALU.
- Latches the ALU result and hands it to the UART transmitter, then waits for transmit completion.
- Drops a partial frame if the next byte does not arrive within a timeout.

Parameters:
- DATA_WIDTH, 8, operand/result/UART byte width
- SIZEOP, 6, ALU opcode width (low SIZEOP bits of the opcode byte)
- TIMEOUT_CYCLES, 1000000, max clock cycles between bytes of one frame
- CNT_WIDTH, 20, width of the inter-byte timeout counter; must hold TIMEOUT_CYCLES

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  synchronous active-high reset
- i_rx_done  in  1  one-cycle pulse: i_rx_data is valid
- i_rx_data  in  DATA_WIDTH  received byte
- i_tx_done  in  1  one-cycle pulse: transmitter finished the byte
- i_alu_result  in  DATA_WIDTH  combinational ALU output
- o_alu_a  out  DATA_WIDTH  operand A register
- o_alu_b  out  DATA_WIDTH  operand B register
- o_alu_op  out  SIZEOP  opcode register
- o_tx_signal  out  1  one-cycle transmit start pulse
- o_tx_data  out  DATA_WIDTH  byte to transmit (latched result)
- o_busy  out  1  high in every state except GET_A
- o_timeout  out  1  one-cycle pulse when a partial frame is dropped

Behaviour:
- Single clock domain; all registers update on the rising edge of i_clock.
- i_reset is synchronous and active-high.
- Reset values:
  - state=GET_A
  - o_alu_a=0, o_alu_b=0, o_alu_op=0, o_tx_data=0
  - o_tx_signal=0, o_timeout=0, o_busy=0
  - timeout counter=0
- Reset applied in any state, including mid-frame or in WAIT_TX, aborts the frame with no transmit pulse.
- GET_A: on i_rx_done, o_alu_a<=i_rx_data, clear counter, ->GET_B.
- GET_B: on i_rx_done, o_alu_b<=i_rx_data, clear counter, ->GET_OP.
- GET_OP: on i_rx_done, o_alu_op<=i_rx_data[SIZEOP-1:0], ->EXEC. Upper opcode-byte bits are ignored.
- Timeout counter (GET_B and GET_OP only):
  - Increments each cycle without i_rx_done.
  - When it reaches TIMEOUT_CYCLES-1: ->GET_A, pulse o_timeout for 1 cycle, clear counter.
  - o_alu_a/b/op keep their last values.
  - If i_rx_done and expiry coincide, i_rx_done wins and there is no timeout.
- EXEC (1 cycle): o_tx_data<=i_alu_result, ->SEND. The ALU sees stable registered operands during EXEC.
- SEND (1 cycle): o_tx_signal=1, ->WAIT_TX. o_tx_signal is registered and high only in this cycle.
- WAIT_TX: on i_tx_done, ->GET_A. No timeout in this state.
- Ignored events:
  - i_rx_done in EXEC/SEND/WAIT_TX: byte dropped, registers unchanged.
  - i_tx_done outside WAIT_TX.
- Latency: opcode i_rx_done at cycle N -> o_tx_data valid at N+2 and o_tx_signal high at N+2.
  - Earliest next frame acceptance: the cycle after i_tx_done.
- o_tx_data holds its value until the next EXEC.
- Back-to-back i_rx_done on consecutive cycles is accepted, one byte per cycle, in GET_A/GET_B/GET_OP.

Optional Feature:
- Macro: SEQ_OPCODE_CHECK_EN.
- Defined:
  - In EXEC, if o_alu_op is not one of {0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x03 SRA, 0x02 SRL}, load o_tx_data<=8'hEE instead of i_alu_result.
  - Timing and the SEND pulse are unchanged.
  - Adds output o_op_err: 1 bit, registered, high from EXEC until the next EXEC or reset; reset value 0.
- Undefined: every opcode is passed through; o_op_err port absent.

Test Plan:
- Reset then frame 0x05, 0x03, 0x20 with ALU model returning a+b -> o_alu_a=0x05, o_alu_b=0x03, o_alu_op=0x20; o_tx_data=0x08 and o_tx_signal 1-cycle pulse exactly 2 cycles after the opcode i_rx_done; i_tx_done returns o_busy to 0.
- Opcode byte 0xE2 -> o_alu_op=0x22 (upper bits ignored); ALU a-b with 0x10, 0x01 -> o_tx_data=0x0F.
- TIMEOUT_CYCLES=16: send 0x07, then nothing -> o_timeout pulse 16 cycles later, state GET_A; next bytes 0x01, 0x02, 0x20 produce 0x03.
- Extra i_rx_done 0x55 during WAIT_TX -> ignored; o_alu_a unchanged; following frame processes correctly.
- i_reset asserted in GET_OP after 2 bytes -> all outputs 0 next cycle, no o_tx_signal; new full frame works.
- With SEQ_OPCODE_CHECK_EN: opcode 0x3F -> o_tx_data=0xEE and o_op_err=1; next frame opcode 0x24 -> o_op_err=0.
